// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared encodings for the memory-access stage.
//   - ADDR_BUS / DATA_BUS : default address and data bus widths
//   - MEM_WIDTH_*         : encodings of the mem_width request field
//   - mau_state_e         : FSM state encoding of mem_access_unit
//   - is_misaligned()     : illegal low-address-bit check for an access width
package mem_access_unit_pkg;

  localparam int unsigned ADDR_BUS = 32;
  localparam int unsigned DATA_BUS = 32;

  localparam logic [1:0] MEM_WIDTH_BYTE = 2'd0;
  localparam logic [1:0] MEM_WIDTH_HALF = 2'd1;
  localparam logic [1:0] MEM_WIDTH_WORD = 2'd2;
  // 2'd3 is reserved and behaves as a word access.

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBus  = 2'd1,
    StDone = 2'd2
  } mau_state_e;

  function automatic logic is_misaligned(logic [1:0] width, logic [1:0] addr_lo);
    logic mis;
    case (width)
      MEM_WIDTH_BYTE: mis = 1'b0;
      MEM_WIDTH_HALF: mis = addr_lo[0];
      default:        mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: multi-cycle data-memory bus.
//   bus_req   : request held high until bus_ack
//   bus_we    : 1 = write
//   bus_addr  : word-aligned address
//   bus_be    : byte enables, one per 8-bit lane
//   bus_wdata : lane-replicated write data
//   bus_ack   : completion from the memory side
//   bus_rdata : read data, valid with bus_ack
// master = requester (mem_access_unit), slave = memory.
interface mem_access_unit_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [3:0]            bus_be;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic                  bus_ack;
  logic [DATA_WIDTH-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational lane steering for 32-bit byte-addressed memory.
//   width       : access width (MEM_WIDTH_*; reserved value acts as word)
//   addr_lo     : addr[1:0] of the access
//   sign_extend : 1 = sign-extend loaded byte/half, 0 = zero-extend
//   store_data  : right-aligned store data
//   load_raw    : raw 32-bit word from the bus
//   byte_en     : byte enables for the access
//   store_lanes : store data replicated across all lanes
//   load_data   : selected and extended load result
// Half accesses use addr_lo[1] only; word accesses ignore addr_lo.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]          width,
  input  logic [1:0]          addr_lo,
  input  logic                sign_extend,
  input  logic [DATA_BUS-1:0] store_data,
  input  logic [DATA_BUS-1:0] load_raw,
  output logic [3:0]          byte_en,
  output logic [DATA_BUS-1:0] store_lanes,
  output logic [DATA_BUS-1:0] load_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    byte_en     = 4'b1111;
    store_lanes = store_data;
    load_data   = load_raw;
    sel_byte    = load_raw[{addr_lo, 3'b000} +: 8];
    sel_half    = addr_lo[1] ? load_raw[31:16] : load_raw[15:0];
    unique case (width)
      MEM_WIDTH_BYTE: begin
        byte_en     = 4'b0001 << addr_lo;
        store_lanes = {4{store_data[7:0]}};
        load_data   = {{24{sign_extend & sel_byte[7]}}, sel_byte};
      end
      MEM_WIDTH_HALF: begin
        byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_lanes = {2{store_data[15:0]}};
        load_data   = {{16{sign_extend & sel_half[15]}}, sel_half};
      end
      default: begin
        byte_en     = 4'b1111;
        store_lanes = store_data;
        load_data   = load_raw;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-access stage responder. Captures a load/store from the
// execute-to-memory register, runs it on the multi-cycle bus and returns the
// extended load result.
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush        : discard the current or pending result
//   mem_enable   : request present; mem_rw 1 = store, 0 = load
//   mem_width    : 0 byte, 1 half, 2 word, 3 reserved (word)
//   sign_extend  : load extension mode
//   addr         : byte address; write_data: right-aligned store data
//   stall_req    : holds the upstream pipeline
//   read_data    : extended load result, held until the next completed load
//   read_valid   : one-cycle load-result strobe
//   mem_fault    : one-cycle fault strobe (bus timeout, or misalignment)
//   bus          : data-memory bus, master side
// Optional feature macro: MEM_ALIGN_EXC_EN -- misaligned half/word accesses skip
// the bus and raise mem_fault. Without it, illegal low address bits are ignored.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = ADDR_BUS,
  parameter int unsigned DATA_WIDTH     = DATA_BUS,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  mem_enable,
  input  logic                  mem_rw,
  input  logic [1:0]            mem_width,
  input  logic                  sign_extend,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  stall_req,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  mem_fault,
  mem_access_unit_if.master     bus
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  mau_state_e state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  fault_q, fault_d;
  logic                  discard_q, discard_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            width_q;
  logic                  rw_q;
  logic                  sext_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] read_data_q;

  logic                  accept;
  logic                  capture;
  logic                  load_upd;
  logic                  misaligned;
  logic                  in_bus;
  logic                  in_done;
  logic [3:0]            lane_be;
  logic [DATA_WIDTH-1:0] lane_wdata;
  logic [DATA_WIDTH-1:0] lane_rdata;

`ifdef MEM_ALIGN_EXC_EN
  assign misaligned = is_misaligned(mem_width, addr[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  assign accept  = (state_q == StIdle) && mem_enable && !flush;
  assign in_bus  = (state_q == StBus);
  assign in_done = (state_q == StDone);

  // Lane steering runs from the captured request so bus outputs stay stable in BUS.
  mem_lane_align u_lane_align (
    .width       (width_q),
    .addr_lo     (addr_q[1:0]),
    .sign_extend (sext_q),
    .store_data  (wdata_q),
    .load_raw    (bus.bus_rdata),
    .byte_en     (lane_be),
    .store_lanes (lane_wdata),
    .load_data   (lane_rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fault_d   = fault_q;
    discard_d = discard_q;
    capture   = 1'b0;
    load_upd  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          capture = 1'b1;
          cnt_d   = '0;
          if (misaligned) begin
            fault_d = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StBus;
          end
        end
      end
      StBus: begin
        // The bus cannot be aborted; a flush only marks the result for discard.
        if (flush) discard_d = 1'b1;
        if (bus.bus_ack) begin
          load_upd = !rw_q;
          state_d  = StDone;
        end else if (cnt_q == CntLast) begin
          fault_d = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        fault_d   = 1'b0;
        discard_d = 1'b0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      fault_q     <= 1'b0;
      discard_q   <= 1'b0;
      addr_q      <= '0;
      width_q     <= 2'b00;
      rw_q        <= 1'b0;
      sext_q      <= 1'b0;
      wdata_q     <= '0;
      read_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fault_q   <= fault_d;
      discard_q <= discard_d;
      if (capture) begin
        addr_q  <= addr;
        width_q <= mem_width;
        rw_q    <= mem_rw;
        sext_q  <= sign_extend;
        wdata_q <= write_data;
      end
      if (load_upd) read_data_q <= lane_rdata;
    end
  end

  assign stall_req     = accept || in_bus;
  assign read_data     = read_data_q;
  assign read_valid    = in_done && !rw_q && !fault_q && !discard_q && !flush;
  assign mem_fault     = in_done && fault_q && !discard_q && !flush;

  assign bus.bus_req   = in_bus;
  assign bus.bus_we    = in_bus && rw_q;
  assign bus.bus_addr  = in_bus ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign bus.bus_be    = in_bus ? lane_be : 4'b0000;
  assign bus.bus_wdata = in_bus ? lane_wdata : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit (TIMEOUT_CYCLES = 4).
// The driver issues requests and plays the memory; expected bus transactions,
// stall/bus-request lengths and results are pushed to queues and a separate
// monitor pops and compares them as the DUT produces them.
// Honours MEM_ALIGN_EXC_EN when the design is built with it.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int unsigned TO = 4;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic        is_fault;
    logic [31:0] data;
  } res_exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        mem_enable = 1'b0;
  logic        mem_rw = 1'b0;
  logic [1:0]  mem_width = 2'b00;
  logic        sign_extend = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] write_data = '0;
  logic        stall_req;
  logic [31:0] read_data;
  logic        read_valid;
  logic        mem_fault;

  mem_access_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_access_unit #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .mem_enable  (mem_enable),
    .mem_rw      (mem_rw),
    .mem_width   (mem_width),
    .sign_extend (sign_extend),
    .addr        (addr),
    .write_data  (write_data),
    .stall_req   (stall_req),
    .read_data   (read_data),
    .read_valid  (read_valid),
    .mem_fault   (mem_fault),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  bus_exp_t bus_q[$];
  res_exp_t res_q[$];
  int       stall_q[$];
  int       blen_q[$];
  int       n_checks = 0;
  int       n_fail = 0;
  bit       mon_en = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: DUT event with nothing expected", name);
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned nbytes(input logic [1:0] w);
    if (w == 2'd0) return 1;
    if (w == 2'd1) return 2;
    return 4;
  endfunction

  // Lane offset: address rounded down to the access size within the word.
  function automatic int unsigned lane_off(input logic [1:0] w, input logic [31:0] a);
    int unsigned n = nbytes(w);
    return ((a % 4) / n) * n;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] w, input logic [31:0] a);
    logic [3:0] be = '0;
    int unsigned n = nbytes(w);
    int unsigned off = lane_off(w, a);
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + n);
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] w, input logic [31:0] wd);
    logic [31:0] r = '0;
    int unsigned n = nbytes(w);
    for (int i = 0; i < 4; i++) r |= ((wd >> (8 * (i % n))) & 32'hFF) << (8 * i);
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] w, input logic [31:0] a,
                                             input bit sx, input logic [31:0] rd);
    int unsigned n = nbytes(w);
    logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    logic [31:0] v = (rd >> (8 * lane_off(w, a))) & mask;
    logic [31:0] sbit = 32'd1 << (8 * n - 1);
    if (sx && n < 4 && (v & sbit) != 0) v = v | ~mask;
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic run_txn(input bit rw, input logic [1:0] w, input bit sx, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int ack_dly,
                         input bit no_ack, input int flush_at);
    bit       mis = 1'b0;
    int       nbus = no_ack ? int'(TO) : ack_dly + 1;
    bit       flushed;
    bus_exp_t be_e;
    res_exp_t re;
`ifdef MEM_ALIGN_EXC_EN
    mis = (a % nbytes(w)) != 0;
`endif
    flushed = !mis && (flush_at >= 0) && (flush_at < nbus);
    stall_q.push_back(mis ? 1 : 1 + nbus);
    if (!mis) begin
      be_e.addr  = a & 32'hFFFF_FFFC;
      be_e.be    = model_be(w, a);
      be_e.we    = rw;
      be_e.wdata = model_wdata(w, wd);
      bus_q.push_back(be_e);
      blen_q.push_back(nbus);
    end
    if (mis || (!flushed && no_ack)) begin
      re.is_fault = 1'b1;
      re.data     = '0;
      res_q.push_back(re);
    end else if (!flushed && !rw) begin
      re.is_fault = 1'b0;
      re.data     = model_load(w, a, sx, rd);
      res_q.push_back(re);
    end

    @(posedge clk); #1;
    mem_enable  = 1'b1;
    mem_rw      = rw;
    mem_width   = w;
    sign_extend = sx;
    addr        = a;
    write_data  = wd;
    @(posedge clk); #1;
    mem_enable  = 1'b0;
    addr        = $urandom;
    write_data  = $urandom;
    if (!mis) begin
      for (int j = 0; j < nbus; j++) begin
        flush         = (j == flush_at);
        bus.bus_ack   = !no_ack && (j == ack_dly);
        bus.bus_rdata = bus.bus_ack ? rd : $urandom;
        @(posedge clk); #1;
      end
      flush       = 1'b0;
      bus.bus_ack = 1'b0;
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    int       srun = 0;
    int       brun = 0;
    logic     prev_req = 1'b0;
    bus_exp_t be_e;
    res_exp_t re;
    forever begin
      @(negedge clk);
      if (!rst_n || !mon_en) begin
        srun = 0;
        brun = 0;
        prev_req = 1'b0;
      end else begin
        if (stall_req) srun++;
        else if (srun > 0) begin
          if (stall_q.size() == 0) fail_event("stall_run");
          else check32("stall_len", srun, stall_q.pop_front());
          srun = 0;
        end
        if (bus.bus_req) brun++;
        else if (brun > 0) begin
          if (blen_q.size() == 0) fail_event("bus_req_run");
          else check32("bus_req_len", brun, blen_q.pop_front());
          brun = 0;
        end
        if (bus.bus_req && !prev_req) begin
          if (bus_q.size() == 0) fail_event("bus_start");
          else begin
            be_e = bus_q.pop_front();
            check32("bus_addr", bus.bus_addr, be_e.addr);
            check32("bus_be", {28'd0, bus.bus_be}, {28'd0, be_e.be});
            check32("bus_we", {31'd0, bus.bus_we}, {31'd0, be_e.we});
            if (be_e.we) check32("bus_wdata", bus.bus_wdata, be_e.wdata);
          end
        end
        if (read_valid || mem_fault) begin
          if (read_valid && mem_fault) fail_event("valid_and_fault");
          else if (res_q.size() == 0) fail_event(read_valid ? "read_valid" : "mem_fault");
          else begin
            re = res_q.pop_front();
            check32("result_is_fault", {31'd0, mem_fault}, {31'd0, re.is_fault});
            if (!re.is_fault) check32("read_data", read_data, re.data);
          end
        end
        prev_req = bus.bus_req;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.bus_ack   = 1'b0;
    bus.bus_rdata = '0;
    #12;
    check32("rst_bus_req", {31'd0, bus.bus_req}, 32'd0);
    check32("rst_bus_we", {31'd0, bus.bus_we}, 32'd0);
    check32("rst_read_valid", {31'd0, read_valid}, 32'd0);
    check32("rst_mem_fault", {31'd0, mem_fault}, 32'd0);
    check32("rst_stall_req", {31'd0, stall_req}, 32'd0);
    check32("rst_bus_addr", bus.bus_addr, 32'd0);
    check32("rst_bus_be", {28'd0, bus.bus_be}, 32'd0);
    check32("rst_bus_wdata", bus.bus_wdata, 32'd0);
    check32("rst_read_data", read_data, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Directed cases.
    run_txn(1'b1, 2'd2, 1'b0, 32'h1004, 32'hDEAD_BEEF, 32'h0, 1, 1'b0, -1);
    run_txn(1'b0, 2'd0, 1'b1, 32'h2003, 32'h0, 32'h8011_2233, 0, 1'b0, -1);
    run_txn(1'b0, 2'd0, 1'b0, 32'h2003, 32'h0, 32'h8011_2233, 2, 1'b0, -1);
    run_txn(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_ABCD, 32'h0, 0, 1'b0, -1);
    run_txn(1'b0, 2'd2, 1'b0, 32'h3000, 32'h0, 32'h0, 0, 1'b1, -1);
    run_txn(1'b0, 2'd1, 1'b1, 32'h4002, 32'h0, 32'h8765_4321, 3, 1'b0, 1);
    run_txn(1'b0, 2'd1, 1'b1, 32'h4002, 32'h0, 32'h8765_4321, int'(TO) - 1, 1'b0, -1);
    run_txn(1'b0, 2'd2, 1'b0, 32'h1001, 32'h0, 32'hCAFE_F00D, 0, 1'b0, -1);
    run_txn(1'b1, 2'd3, 1'b0, 32'h5000, 32'h1234_5678, 32'h0, 0, 1'b0, -1);

    // A request qualified by flush in IDLE must be ignored entirely.
    @(posedge clk); #1;
    mem_enable = 1'b1;
    flush      = 1'b1;
    @(posedge clk); #1;
    mem_enable = 1'b0;
    flush      = 1'b0;

    // Randomized traffic.
    for (int t = 0; t < 80; t++) begin
      int fa;
      int ad;
      bit na;
      ad = int'($urandom_range(0, TO - 1));
      na = ($urandom_range(0, 9) == 0);
      fa = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, TO - 1)) : -1;
      run_txn($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 1),
              $urandom, $urandom, $urandom, ad, na, fa);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    repeat (3) @(posedge clk);

    // Reset in the middle of a bus transaction.
    mon_en = 1'b0;
    @(posedge clk); #1;
    mem_enable = 1'b1;
    mem_rw     = 1'b0;
    mem_width  = 2'd2;
    addr       = 32'h6000;
    @(posedge clk); #1;
    mem_enable = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check32("midrst_bus_req", {31'd0, bus.bus_req}, 32'd0);
    check32("midrst_stall_req", {31'd0, stall_req}, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    run_txn(1'b0, 2'd0, 1'b1, 32'h7001, 32'h0, 32'h0000_FF00, 1, 1'b0, -1);
    repeat (4) @(posedge clk);

    check32("stall_q_drained", stall_q.size(), 32'd0);
    check32("blen_q_drained", blen_q.size(), 32'd0);
    check32("bus_q_drained", bus_q.size(), 32'd0);
    check32("res_q_drained", res_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
